// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forward-select encodings, result-source codes,
// and the mul/div sequencer state encoding.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwdSel_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdState_t;

  localparam int CNT_W = 5;

endpackage

// File: rtl/mdu_sequencer.sv
// IDLE/BUSY sequencer that holds the pipeline while a multi-cycle mul/div op
// occupies the execute stage; current state is exported for observation.
module mdu_sequencer
  import pipeline_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdStart,
  input  logic pcSrc,
  output logic mdStall,
  output logic mdState
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 2);

  mdState_t         state;
  mdState_t         stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // The stall covers the start cycle plus MDU_LAT-2 busy cycles; cnt==0 is the release cycle.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    mdStall   = 1'b0;
    case (state)
      IDLE: begin
        if (mdStart && !pcSrc) begin
          mdStall   = 1'b1;
          stateNext = BUSY;
          cntNext   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          mdStall = 1'b1;
          cntNext = cnt - CNT_W'(1);
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign mdState = logic'(state);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and
// mul/div stall sequencing. Define HAZARD_PERF_EN to add stall/flush counters.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int A_WIDTH = 5,
  parameter int MDU_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [A_WIDTH-1:0] Rs1D,
  input  logic [A_WIDTH-1:0] Rs2D,
  input  logic [A_WIDTH-1:0] Rs1E,
  input  logic [A_WIDTH-1:0] Rs2E,
  input  logic [A_WIDTH-1:0] RdE,
  input  logic [A_WIDTH-1:0] RdM,
  input  logic [A_WIDTH-1:0] RdW,
  input  logic               RegWriteM,
  input  logic               RegWriteW,
  input  logic [1:0]         ResultSrcE,
  input  logic               PCSrcE,
  input  logic               MdStartE,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE,
  output logic               StallF,
  output logic               StallD,
  output logic               StallE,
  output logic               FlushD,
  output logic               FlushE,
  output logic               FlushM,
  output logic               MdBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        StallCnt,
  output logic [31:0]        FlushCnt
`endif
);

  logic mdStall;
  logic mdState;
  logic loadUse;
  logic luStall;

  function automatic logic [1:0] fwdSel(input logic [A_WIDTH-1:0] rs,
                                        input logic               regWriteM,
                                        input logic [A_WIDTH-1:0] rdM,
                                        input logic               regWriteW,
                                        input logic [A_WIDTH-1:0] rdW);
    logic [1:0] sel;
    sel = FWD_RF;
    if (regWriteM && (rdM != '0) && (rdM == rs))      sel = FWD_MEM;
    else if (regWriteW && (rdW != '0) && (rdW == rs)) sel = FWD_WB;
    return sel;
  endfunction

  mdu_sequencer #(.MDU_LAT(MDU_LAT)) uSeq (
    .clk     (clk),
    .rst_n   (rst_n),
    .mdStart (MdStartE),
    .pcSrc   (PCSrcE),
    .mdStall (mdStall),
    .mdState (mdState)
  );

  assign MdBusy = (mdState == logic'(BUSY));

  assign ForwardAE = fwdSel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwdSel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  assign loadUse = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

  // A taken branch squashes the dependent instruction, so no load-use hold is needed.
  assign luStall = loadUse && !PCSrcE && !MdBusy;

  assign StallF = mdStall || luStall;
  assign StallD = mdStall || luStall;
  assign StallE = mdStall;
  assign FlushM = mdStall;
  assign FlushD = !MdBusy && PCSrcE;
  assign FlushE = !MdBusy && (PCSrcE || loadUse);

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCntQ;
  logic [31:0] flushCntQ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (StallF && (stallCntQ != 32'hFFFF_FFFF))
        stallCntQ <= stallCntQ + 32'd1;
      if ((FlushD || FlushE) && (flushCntQ != 32'hFFFF_FFFF))
        flushCntQ <= flushCntQ + 32'd1;
    end
  end

  assign StallCnt = stallCntQ;
  assign FlushCnt = flushCntQ;
`endif

`ifndef SYNTHESIS
  // Starting a mul/div in the same cycle as a taken branch is illegal upstream.
  mdStartWithBranch: assert property (@(posedge clk) disable iff (!rst_n)
    !(MdStartE && PCSrcE && !MdBusy));
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter A_WIDTH, default 5, register-address width.
REQ-002 Parameter MDU_LAT, default 4, total execute-stage cycles of a multi-cycle mul/div op; legal range 2..32.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 Rs1D, Rs2D  in  A_WIDTH  decode-stage source registers.
REQ-006 Rs1E, Rs2E, RdE  in  A_WIDTH  execute-stage sources/destination.
REQ-007 RdM, RdW  in  A_WIDTH  memory/writeback destinations.
REQ-008 RegWriteM, RegWriteW  in  1  M/W register-write enables.
REQ-009 ResultSrcE  in  2  E-stage result select; 2'b01 = load.
REQ-010 PCSrcE  in  1  taken branch/jump resolved in E.
REQ-011 MdStartE  in  1  E-stage instruction is multi-cycle mul/div.
REQ-012 ForwardAE, ForwardBE  out  2  SrcA/SrcB select: 00 register file, 10 M ALUResult, 01 W Result.
REQ-013 StallF, StallD, StallE  out  1  hold F/D/E pipeline registers.
REQ-014 FlushD, FlushE, FlushM  out  1  bubble-insert into D/E/M registers.
REQ-015 MdBusy  out  1  high while sequencer in BUSY.

Function
REQ-016 Forwarding SHALL be combinational: M match (RegWriteM, RdM!=0, RdM==RsxE) -> 10; else W match -> 01; else 00; M wins when both match.
REQ-017 Source register x0 SHALL never be forwarded.
REQ-018 Load-use: ResultSrcE==01, RdE!=0, RdE equals Rs1D or Rs2D -> StallF=StallD=FlushE=1 same cycle, one-cycle bubble.
REQ-019 PCSrcE=1 in IDLE SHALL assert FlushD=FlushE=1 same cycle, overriding load-use StallF/StallD.
REQ-020 Sequencer states IDLE, BUSY; 5-bit down-counter cnt.
REQ-021 IDLE with MdStartE=1 and PCSrcE=0: StallF=StallD=StallE=FlushM=1 combinationally; next state BUSY, cnt<=MDU_LAT-2.
REQ-022 BUSY, cnt!=0: StallF=StallD=StallE=FlushM=1, cnt decrements.
REQ-023 BUSY, cnt==0: all stalls and FlushM deasserted, op advances to M, next state IDLE.
REQ-024 Net effect: MdStartE first seen cycle T -> stalls asserted T..T+MDU_LAT-2 (MDU_LAT-1 cycles), release at T+MDU_LAT-1.
REQ-025 In BUSY, FlushD and FlushE SHALL be 0 regardless of PCSrcE or load-use inputs; forwarding continues.
REQ-026 MdStartE with PCSrcE in IDLE: PCSrcE wins, sequencer stays IDLE (illegal combination, flagged by assertion).
REQ-027 MdStartE re-asserted in the release cycle SHALL be ignored; a new op starts only from IDLE.
REQ-028 All stall/flush/forward outputs combinational from inputs and state; no added latency.

Reset
REQ-029 rst_n low at a clock edge: state<=IDLE, cnt<=0, perf counters<=0; MdBusy=0 next cycle.
REQ-030 Reset mid-BUSY SHALL abort the op; stalls drop the cycle after reset is sampled.

Configuration
REQ-031 Macro HAZARD_PERF_EN defined: add outputs StallCnt[31:0] (+1 each cycle StallF=1) and FlushCnt[31:0] (+1 each cycle FlushE=1 or FlushD=1), both saturating at 32'hFFFF_FFFF.
REQ-032 HAZARD_PERF_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-033 Shared package pipeline_pkg SHALL hold forward-select enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10), RESULT_LOAD=2'b01, sequencer state enum.
REQ-034 Sub-module mdu_sequencer SHALL contain the IDLE/BUSY FSM and counter; forwarding and load-use logic stay in hazard_ctrl.

Verification
REQ-035 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; RdM=0 with Rs1E=0 -> 00.
REQ-036 ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 one cycle; RdE=0 -> no stall.
REQ-037 MDU_LAT=4, MdStartE at cycle 10 -> StallE/FlushM high cycles 10-12, low cycle 13, MdBusy high cycles 11-13.
REQ-038 PCSrcE=1 and load-use same cycle -> FlushD=FlushE=1, StallF=StallD=0.
REQ-039 rst_n low at cycle 12 of REQ-037 op -> IDLE, stalls low from cycle 13; PCSrcE during BUSY -> FlushD=FlushE=0.
REQ-040 HAZARD_PERF_EN: force StallCnt to 32'hFFFF_FFFE, two stall cycles -> holds 32'hFFFF_FFFF.
